gpio_word_assembler: RTL
========================

# gpio_word_assembler

Front-end register-write stage between the PS GPIO bus and every GPIO-programmed register and LUT in `experiment_top_level_wrapper`. It synchronizes the software-driven write strobe and detects its rising edge. It assembles each 16-bit value from two consecutive byte writes to the same address, high byte first, and emits one single-cycle word-write strobe to the downstream decoders: phase-start registers, output-scaler LUTs, and MAC/NL driver LUTs. It also reports framing health on the GPIO readback bus.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles a half-assembled word may wait for its low byte before it is discarded; legal range 1..65535.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `gpio_in`  in  32  bits [15:0] address, [23:16] data byte, [24] `w_clk` write strobe, [31:25] ignored.
- `wr_valid`  out  1  one-cycle strobe marking a completed 16-bit word.
- `wr_addr`  out  16  address of the completed word.
- `wr_data`  out  16  completed word, {high byte, low byte}.
- `pending`  out  1  high byte is held and waiting for its low byte.
- `gpio_out_bus`  out  32  status: [31:24] resync_count, [23:16] timeout_count, [15:0] word_count.

## Operation
- `w_clk` passes through a 2-FF synchronizer plus one history FF. `edge` = sync2 & ~sync3.
- On `edge`, address and data are sampled from `gpio_in`. Software holds both stable from at least 1 cycle before `w_clk` rises until it falls.
- FSM has two states:
  - IDLE, on edge: latch `hi_byte` and `hold_addr`, go to HAVE_HI.
  - HAVE_HI, on edge with address = `hold_addr`: emit `wr_valid` with {hi_byte, byte}, increment `word_count`, go to IDLE.
  - HAVE_HI, on edge with a different address: discard the held byte, latch the new byte and address as the new high byte, increment `resync_count`, stay in HAVE_HI.
  - HAVE_HI, timeout counter reaches `TIMEOUT_CYCLES` with no edge: discard the held byte, increment `timeout_count`, go to IDLE.
- Timeout counter is 16 bits. It clears on entry to HAVE_HI and on every edge, and counts only while in HAVE_HI.
- If an edge and the timeout expiry occur in the same cycle, the edge wins: it is processed as a normal HAVE_HI edge and no timeout is counted.
- `word_count` wraps modulo 2^16.
- `resync_count` and `timeout_count` saturate at 255.
- `pending` is high exactly when the FSM is in HAVE_HI.
- `wr_addr` and `wr_data` hold their last value between strobes.
- Data is passed through unchanged and unsigned. Sign interpretation belongs to the consumers; LUT FSM addresses are 2's-complement -128..127.

## Timing
- Reset values: state IDLE, all synchronizer FFs 0, `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `pending` 0, all counters 0, `gpio_out_bus` 0.
- Latency: `w_clk` first sampled high at clk edge N. `edge` is asserted during the cycle after edge N+1 and acted on at edge N+2.
  - `wr_valid` is high for exactly one cycle, from edge N+2 to N+3.
  - `pending` and the status counters update at edge N+2.
- `w_clk` must stay high for at least 1 cycle and low for at least 1 cycle between writes. A level held high for any length produces exactly one edge.
- Maximum throughput is one byte per 2 cycles, so one word per 4 cycles.
- Reset asserted mid-word (HAVE_HI) returns to IDLE immediately and drops the held byte. After reset, the next edge is treated as a high byte.
- A `w_clk` already high when `rst` deasserts produces an edge 2 cycles later. Software must not do this.
- No backpressure: downstream must accept `wr_valid` in any cycle.

## Structure
- Add GPIO field positions `gpio_addr_lsb`, `gpio_data_lsb`, `gpio_wclk_bit` and the status field layout to `ising_config`. Register address constants are already there.
- Sub-module `gpio_strobe_sync`: 2-FF synchronizer plus edge detect, with ports `clk`, `rst`, `async_in`, `rise`. It is reused wherever PS-driven strobes enter.
- The FSM, timeout counter and status counters stay in `gpio_word_assembler`.

## Test plan
- Write 0x12 then 0x34 to addr 0x0005 (2 cycles setup, 2 cycles high) -> single `wr_valid`, `wr_addr`=0x0005, `wr_data`=0x1234, `word_count`=1, `pending` low afterwards.
- Write 0xAB to addr 3, then 0xCD and 0xEF to addr 4 -> `resync_count`=1, one strobe with addr 4, data 0xCDEF, no strobe for addr 3.
- `TIMEOUT_CYCLES`=16, write 0x55 to addr 7, idle 20 cycles, then write 0x66 to addr 7 -> `timeout_count`=1 at cycle 16 of waiting, no strobe, `pending` high again after the second write.
- Assert `rst` for 1 cycle while `pending`=1, then write 0x01 and 0x02 to addr 9 -> outputs zeroed during reset, then `wr_data`=0x0102.
- Load 300 LUT entries with 4 bytes each (addr then data register) -> `word_count`=600, resync and timeout counts 0, every strobe matches the file contents in order.
- Force 300 address mismatches -> `resync_count` stays at 255.

Source files
------------

// File: rtl/gpio_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
// gpio_word_assembler_pkg : GPIO bus field layout, status layout, FSM states
// Revision: 1.0
// ============================================================================
package gpio_word_assembler_pkg;

  // PS GPIO write-bus fields
  localparam int unsigned c_gpio_addr_lsb = 0;
  localparam int unsigned c_gpio_data_lsb = 16;
  localparam int unsigned c_gpio_wclk_bit = 24;

  // Readback status fields
  localparam int unsigned c_stat_word_lsb    = 0;
  localparam int unsigned c_stat_timeout_lsb = 16;
  localparam int unsigned c_stat_resync_lsb  = 24;

  // LUT programming register addresses
  localparam logic [15:0] c_reg_lut_addr = 16'h0040;
  localparam logic [15:0] c_reg_lut_data = 16'h0041;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_HAVE_HI = 1'b1
  } asm_state_e;

  typedef struct packed {
    logic [7:0]  resync_count;
    logic [7:0]  timeout_count;
    logic [15:0] word_count;
  } status_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_word_assembler_strobe_sync.sv
`default_nettype none
// ============================================================================
// gpio_strobe_sync : 2-FF synchronizer plus history FF, rising-edge pulse
// Revision: 1.0
// ============================================================================
module gpio_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule
`default_nettype wire

// File: rtl/gpio_word_assembler.sv
`default_nettype none
// ============================================================================
// gpio_word_assembler : pairs GPIO byte writes (high first) into 16-bit words
// Revision: 1.0
// ============================================================================
module gpio_word_assembler
  import gpio_word_assembler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        pending,
  output logic [31:0] gpio_out_bus
);

  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

  logic        w_rise;
  logic [15:0] w_addr;
  logic [7:0]  w_byte;
  logic        w_expire;
  logic        w_unused_bits;

  asm_state_e  state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] hold_addr_q, hold_addr_d;
  logic [15:0] tmo_q, tmo_d;
  logic        valid_q, valid_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  status_t     status_q, status_d;

  gpio_strobe_sync u_wclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (gpio_in[c_gpio_wclk_bit]),
    .rise     (w_rise)
  );

  assign w_addr        = gpio_in[c_gpio_addr_lsb +: 16];
  assign w_byte        = gpio_in[c_gpio_data_lsb +: 8];
  assign w_unused_bits = ^gpio_in[31:25];
  assign w_expire      = (tmo_q == c_tmo_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      hold_addr_q <= '0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      hold_addr_q <= hold_addr_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      status_q    <= status_d;
    end
  end

  // An edge takes priority over a coinciding timeout expiry.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    hold_addr_d = hold_addr_q;
    tmo_d       = '0;
    valid_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    status_d    = status_q;
    case (state_q)
      ST_IDLE: begin
        if (w_rise) begin
          hi_d        = w_byte;
          hold_addr_d = w_addr;
          state_d     = ST_HAVE_HI;
        end
      end
      ST_HAVE_HI: begin
        if (w_rise) begin
          if (w_addr == hold_addr_q) begin
            valid_d             = 1'b1;
            addr_d              = w_addr;
            data_d              = {hi_q, w_byte};
            status_d.word_count = status_q.word_count + 16'd1;
            state_d             = ST_IDLE;
          end else begin
            hi_d                  = w_byte;
            hold_addr_d           = w_addr;
            status_d.resync_count = sat_inc8(status_q.resync_count);
          end
        end else if (w_expire) begin
          status_d.timeout_count = sat_inc8(status_q.timeout_count);
          state_d                = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_valid     = valid_q;
  assign wr_addr      = addr_q;
  assign wr_data      = data_q;
  assign pending      = (state_q == ST_HAVE_HI);
  assign gpio_out_bus = {status_q.resync_count, status_q.timeout_count, status_q.word_count};

endmodule
`default_nettype wire
